// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, shared types and the colour-bar table
// for the VGA scan controller.
package vga_timing_pkg;

   localparam int H_ACTIVE      = 640;
   localparam int H_FP          = 16;
   localparam int H_SYNC        = 96;
   localparam int H_BP          = 48;
   localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE      = 480;
   localparam int V_FP          = 10;
   localparam int V_SYNC        = 2;
   localparam int V_BP          = 33;
   localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PIXEL_LATENCY = 2;

   localparam int ADDR_WIDTH  = 19;
   localparam int PIXEL_WIDTH = 24;
   localparam int CNT_WIDTH   = 10;
   localparam int BAR_WIDTH   = 80;

   typedef logic [ADDR_WIDTH-1:0]  addr_t;
   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
   localparam pixel_t BAR_COLOURS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
`ifdef VGA_TEST_PATTERN_EN
      logic [CNT_WIDTH-1:0] x;
`endif
   } timing_t;

   function automatic pixel_t bar_colour(input logic [CNT_WIDTH-1:0] x);
      pixel_t c = BAR_COLOURS[0];
      for (int i = 1; i < 8; i++) begin
         if (int'(x) >= i * BAR_WIDTH) c = BAR_COLOURS[i];
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Renderer/DAC-facing signal bundle of the VGA scan controller; master is
// the controller, slave is the renderer plus pin side.
interface vga_scan_controller_if;
   import vga_timing_pkg::*;

   pixel_t      iPixel;
   addr_t       oAddress;
   logic        oFrameStart;
   logic        oActive;
   logic        oHSync;
   logic        oVSync;
   logic        oBlank_n;
   logic        oSync_n;
   logic [7:0]  oR;
   logic [7:0]  oG;
   logic [7:0]  oB;

   modport master (
      input  iPixel,
      output oAddress, oFrameStart, oActive, oHSync, oVSync,
             oBlank_n, oSync_n, oR, oG, oB
   );

   modport slave (
      output iPixel,
      input  oAddress, oFrameStart, oActive, oHSync, oVSync,
             oBlank_n, oSync_n, oR, oG, oB
   );

endinterface

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with synchronous reset value; also exposes
// the value about to enter the last stage so a sibling register can align with it.
module vga_delay_line #(
   parameter int               WIDTH       = 1,
   parameter int               DEPTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] tap,
   output logic [WIDTH-1:0] delayed
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge iClock) begin
      if (iReset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
      end else begin
         stage[0] <= data;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign delayed = stage[DEPTH-1];

   generate
      if (DEPTH == 1) begin : g_tap_input
         assign tap = data;
      end else begin : g_tap_stage
         assign tap = stage[DEPTH-2];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster timing + linear pixel address; sync/blank delayed PIXEL_LATENCY clocks
// to meet the returned colour. VGA_TEST_PATTERN_EN swaps iPixel for colour bars.
module vga_scan_controller #(
   parameter int H_ACTIVE      = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP          = vga_timing_pkg::H_FP,
   parameter int H_SYNC        = vga_timing_pkg::H_SYNC,
   parameter int H_BP          = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE      = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP          = vga_timing_pkg::V_FP,
   parameter int V_SYNC        = vga_timing_pkg::V_SYNC,
   parameter int V_BP          = vga_timing_pkg::V_BP,
   parameter int PIXEL_LATENCY = vga_timing_pkg::PIXEL_LATENCY
) (
   input  logic                   iClock,
   input  logic                   iReset,
   vga_scan_controller_if.master  vga
);
   import vga_timing_pkg::*;

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(HT - 1);
   localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(VT - 1);
   localparam logic [CNT_WIDTH-1:0] H_VIS    = CNT_WIDTH'(H_ACTIVE);
   localparam logic [CNT_WIDTH-1:0] V_VIS    = CNT_WIDTH'(V_ACTIVE);
   localparam logic [CNT_WIDTH-1:0] HS_FIRST = CNT_WIDTH'(H_ACTIVE + H_FP);
   localparam logic [CNT_WIDTH-1:0] HS_LAST  = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_WIDTH-1:0] VS_FIRST = CNT_WIDTH'(V_ACTIVE + V_FP);
   localparam logic [CNT_WIDTH-1:0] VS_LAST  = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam timing_t TIMING_RESET = '{hs: 1'b1, vs: 1'b1, default: '0};

   logic [CNT_WIDTH-1:0] h_cnt;
   logic [CNT_WIDTH-1:0] v_cnt;
   addr_t                addr;
   logic                 h_last;
   logic                 v_last;
   logic                 active;
   timing_t              stage_in;
   timing_t              stage_tap;
   timing_t              stage_out;
   pixel_t               pixel_src;
   pixel_t               rgb;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);
   assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

   // addr tracks the current position, so it is already 0 when (0,0) is presented.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         h_cnt <= '0;
         v_cnt <= '0;
         addr  <= '0;
      end else begin
         h_cnt <= h_last ? '0 : h_cnt + 1'b1;
         if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         if (h_last && v_last) addr <= '0;
         else if (active)      addr <= addr + 1'b1;
      end
   end

   assign stage_in.hs     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
   assign stage_in.vs     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
   assign stage_in.active = active;
`ifdef VGA_TEST_PATTERN_EN
   assign stage_in.x      = h_cnt;
`endif

   vga_delay_line #(
      .WIDTH       ($bits(timing_t)),
      .DEPTH       (PIXEL_LATENCY),
      .RESET_VALUE (TIMING_RESET)
   ) u_timing_delay (
      .iClock  (iClock),
      .iReset  (iReset),
      .data    (stage_in),
      .tap     (stage_tap),
      .delayed (stage_out)
   );

`ifdef VGA_TEST_PATTERN_EN
   assign pixel_src = bar_colour(stage_tap.x);
`else
   assign pixel_src = vga.iPixel;
`endif

   // Colour is registered on the same edge that moves stage_tap into the last
   // delay stage, so RGB and blank leave together.
   always_ff @(posedge iClock) begin
      if (iReset)               rgb <= '0;
      else if (stage_tap.active) rgb <= pixel_src;
      else                      rgb <= '0;
   end

   assign vga.oAddress    = (active && !iReset) ? addr : '0;
   assign vga.oFrameStart = !iReset && (h_cnt == '0) && (v_cnt == '0);
   assign vga.oActive     = active && !iReset;
   assign vga.oHSync      = stage_out.hs;
   assign vga.oVSync      = stage_out.vs;
   assign vga.oBlank_n    = stage_out.active;
   assign vga.oSync_n     = 1'b0;
   assign vga.oR          = rgb[23:16];
   assign vga.oG          = rgb[15:8];
   assign vga.oB          = rgb[7:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a full 640x480 instance and a shrunken-raster
// instance, both checked every cycle against a position-based model.
module tb_vga_scan_controller;
   import vga_timing_pkg::*;

   localparam int LAT = 2;
   // Shrunken raster: 28 clocks/line, 13 lines/frame, 364 clocks/frame, 96 active pixels.
   localparam int S_HA = 16, S_HFP = 3, S_HS = 5, S_HBP = 4;
   localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_VBP = 3;
   localparam int S_FRAME = 364;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        act;
      logic [18:0] addr;
      logic [9:0]  x;
   } tuple_t;

   localparam tuple_t T_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          pos = 0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   vga_scan_controller_if bus_s ();
   vga_scan_controller_if bus_f ();

   vga_scan_controller #(
      .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
      .PIXEL_LATENCY(LAT)
   ) dut_s (.iClock(clk), .iReset(rst), .vga(bus_s));

   vga_scan_controller dut_f (.iClock(clk), .iReset(rst), .vga(bus_f));

   initial forever #5 clk = ~clk;

   function automatic tuple_t raw_of(input int p_in, input int ha, input int hfp, input int hsw,
                                     input int hbp, input int va, input int vfp, input int vsw,
                                     input int vbp);
      int ht = ha + hfp + hsw + hbp;
      int vt = va + vfp + vsw + vbp;
      int p  = p_in % (ht * vt);
      int h  = p % ht;
      int v  = p / ht;
      tuple_t t;
      t.act  = (h < ha) && (v < va);
      t.addr = t.act ? 19'(v * ha + h) : 19'd0;
      t.hs   = !(h >= ha + hfp && h < ha + hfp + hsw);
      t.vs   = !(v >= va + vfp && v < va + vfp + vsw);
      t.x    = 10'(h);
      return t;
   endfunction

   function automatic logic [23:0] exp_rgb(input tuple_t t);
      if (!t.act) return 24'd0;
`ifdef VGA_TEST_PATTERN_EN
      return bars[int'(t.x) / 80];
`else
      return 24'(t.addr);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s pos=%0d got=%0h want=%0h t=%0t", name, pos, got, want, $time);
      end
   endtask

   task automatic cmp(input string tag, input logic [18:0] a, input logic fs, input logic ac,
                      input logic hs, input logic vs, input logic bn, input logic sn,
                      input logic [23:0] rgb, input tuple_t cur, input bit cur_rst,
                      input bit fs_want, input tuple_t del);
      chk({tag, "_addr"},   32'(a),   cur_rst ? 32'd0 : 32'(cur.addr));
      chk({tag, "_fstart"}, 32'(fs),  32'(fs_want));
      chk({tag, "_active"}, 32'(ac),  cur_rst ? 32'd0 : 32'(cur.act));
      chk({tag, "_hsync"},  32'(hs),  32'(del.hs));
      chk({tag, "_vsync"},  32'(vs),  32'(del.vs));
      chk({tag, "_blank_n"}, 32'(bn), 32'(del.act));
      chk({tag, "_sync_n"}, 32'(sn),  32'd0);
      chk({tag, "_rgb"},    32'(rgb), 32'(exp_rgb(del)));
   endtask

   // Renderer model: the colour for an address is captured by the DUT LAT edges
   // after that address was presented; blanking positions get random junk.
   initial begin
      logic [18:0] as, af;
      logic        acs, acf;
      bus_s.iPixel = '0;
      bus_f.iPixel = '0;
      forever begin
         @(negedge clk);
         as = bus_s.oAddress; acs = bus_s.oActive;
         af = bus_f.oAddress; acf = bus_f.oActive;
         @(posedge clk);
         #2;
         bus_s.iPixel = acs ? 24'(as) : 24'($urandom);
         bus_f.iPixel = acf ? 24'(af) : 24'($urandom);
      end
   end

   initial begin
      bit     prev_rst = 1'b1;
      bit     cur_rst;
      tuple_t pipe_s [LAT];
      tuple_t pipe_f [LAT];
      tuple_t cs, cf, prev_s, prev_f;
      int     act_cnt = 0, hs_low = 0, vs_low = 0;
      logic [23:0] rgb_s, rgb_f;
      prev_s = T_RST;
      prev_f = T_RST;
      forever begin
         @(negedge clk);
         if (prev_rst) begin
            pos = 0;
            for (int i = 0; i < LAT; i++) begin pipe_s[i] = T_RST; pipe_f[i] = T_RST; end
         end else begin
            pos++;
            for (int i = LAT - 1; i > 0; i--) begin pipe_s[i] = pipe_s[i-1]; pipe_f[i] = pipe_f[i-1]; end
            pipe_s[0] = prev_s;
            pipe_f[0] = prev_f;
         end
         cur_rst = rst;
         cs = raw_of(pos, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP);
         cf = raw_of(pos, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP);
         rgb_s = {bus_s.oR, bus_s.oG, bus_s.oB};
         rgb_f = {bus_f.oR, bus_f.oG, bus_f.oB};

         cmp("s", bus_s.oAddress, bus_s.oFrameStart, bus_s.oActive, bus_s.oHSync, bus_s.oVSync,
             bus_s.oBlank_n, bus_s.oSync_n, rgb_s, cs, cur_rst,
             !cur_rst && (pos % S_FRAME == 0), pipe_s[LAT-1]);
         cmp("f", bus_f.oAddress, bus_f.oFrameStart, bus_f.oActive, bus_f.oHSync, bus_f.oVSync,
             bus_f.oBlank_n, bus_f.oSync_n, rgb_f, cf, cur_rst,
             !cur_rst && (pos % 420000 == 0), pipe_f[LAT-1]);

         // Hand-derived points that pin the model itself.
         if (!cur_rst) begin
            case (pos)
               0:   begin chk("lit_f_fstart0", 32'(bus_f.oFrameStart), 32'd1);
                          chk("lit_f_addr0", 32'(bus_f.oAddress), 32'd0); end
               2:   begin chk("lit_f_blank_x0", 32'(bus_f.oBlank_n), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
                          chk("lit_f_rgb_x0", 32'(rgb_f), 32'hFFFFFF); end
               82:  chk("lit_f_rgb_x80", 32'(rgb_f), 32'hFFFF00);
               402: chk("lit_f_rgb_x400", 32'(rgb_f), 32'hFF0000);
               641: chk("lit_f_rgb_x639", 32'(rgb_f), 32'h000000);
`else
                          chk("lit_f_rgb_x0", 32'(rgb_f), 32'd0); end
               3:   chk("lit_f_rgb_x1", 32'(rgb_f), 32'd1);
               641: chk("lit_f_rgb_x639", 32'(rgb_f), 32'd639);
`endif
               28:  chk("lit_s_line1", 32'(bus_s.oAddress), 32'd16);
               155: chk("lit_s_last", 32'(bus_s.oAddress), 32'd95);
               156: chk("lit_s_after_last", 32'(bus_s.oAddress), 32'd0);
               364: chk("lit_s_fstart2", 32'(bus_s.oFrameStart), 32'd1);
               639: chk("lit_f_addr639", 32'(bus_f.oAddress), 32'd639);
               640: begin chk("lit_f_addr640", 32'(bus_f.oAddress), 32'd0);
                          chk("lit_f_active640", 32'(bus_f.oActive), 32'd0); end
               642: begin chk("lit_f_blank642", 32'(bus_f.oBlank_n), 32'd0);
                          chk("lit_f_rgb642", 32'(rgb_f), 32'd0); end
               657: chk("lit_f_hs657", 32'(bus_f.oHSync), 32'd1);
               658: chk("lit_f_hs658", 32'(bus_f.oHSync), 32'd0);
               753: chk("lit_f_hs753", 32'(bus_f.oHSync), 32'd0);
               754: chk("lit_f_hs754", 32'(bus_f.oHSync), 32'd1);
               800: chk("lit_f_line1", 32'(bus_f.oAddress), 32'd640);
               default: ;
            endcase
            if (pos == 364) begin act_cnt = 0; hs_low = 0; vs_low = 0; end
            if (pos >= 364 && pos < 728) begin
               act_cnt += int'(bus_s.oActive);
               hs_low  += int'(!bus_s.oHSync);
               vs_low  += int'(!bus_s.oVSync);
            end
            if (pos == 728) begin
               chk("lit_s_active_per_frame", 32'(act_cnt), 32'd96);
               chk("lit_s_hs_low_per_frame", 32'(hs_low), 32'd65);
               chk("lit_s_vs_low_per_frame", 32'(vs_low), 32'd56);
            end
         end

         prev_s   = cs;
         prev_f   = cf;
         prev_rst = cur_rst;
      end
   end

   initial begin
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      repeat (900) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         #2 rst = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #2 rst = 1'b0;
         repeat ($urandom_range(100, 800)) @(posedge clk);
      end
      repeat (900) @(posedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
